// File: rtl/glb_pkg.sv
// glb_pkg: shared FSM encoding and default widths for the GLB weight loader.
package glb_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    localparam int DEF_DATA_BITWIDTH = 16;
    localparam int DEF_ADDR_BITWIDTH = 10;
    localparam int DEF_FIFO_DEPTH = 4;
endpackage

// File: rtl/weight_loader_fifo.sv
// weight_loader_fifo: synchronous first-word-fall-through staging FIFO with full/empty/count.
module weight_loader_fifo
    import glb_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_BITWIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    // A full FIFO may still take a word when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/glb_weight_loader.sv
// glb_weight_loader: bursts weights from the global buffer into a scratchpad through a FWFT FIFO.
// Define GLB_WEIGHT_LOADER_CHECKSUM_EN to add a running checksum output of transferred words.
module glb_weight_loader
    import glb_pkg::*;
#(
    parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
    parameter int ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_BITWIDTH-1:0] base_addr,
    input  logic [ADDR_BITWIDTH:0]   num_words,
    output logic                     busy,
    output logic                     done,
    output logic                     glb_read_req,
    output logic [ADDR_BITWIDTH-1:0] glb_r_addr,
    input  logic [DATA_BITWIDTH-1:0] glb_r_data,
    output logic                     spad_w_valid,
    input  logic                     spad_w_ready,
    output logic [DATA_BITWIDTH-1:0] spad_w_data,
    output logic [ADDR_BITWIDTH-1:0] spad_w_addr
`ifdef GLB_WEIGHT_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_BITWIDTH-1:0] checksum
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;
    localparam int NW = ADDR_BITWIDTH + 1;
    state_t state;
    logic [NW-1:0] num, issued;
    logic pend, full, empty, pop, can_issue;
    logic [CW-1:0] count;
    logic [DATA_BITWIDTH-1:0] head;
    weight_loader_fifo #(.WIDTH(DATA_BITWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(pend), .din(glb_r_data), .pop(pop),
        .dout(head), .full(full), .empty(empty), .count(count)
    );
    assign spad_w_valid = !empty;
    assign spad_w_data = empty ? '0 : head;
    assign pop = spad_w_valid && spad_w_ready;
    // Decides next cycle's read: occupancy after this edge plus the read now on the bus must leave room
    assign can_issue = !full && (SW'(count) + SW'(pend) + SW'(glb_read_req) - SW'(pop) < SW'(FIFO_DEPTH));
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            num <= '0;
            issued <= '0;
            pend <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            glb_read_req <= 1'b0;
            glb_r_addr <= '0;
            spad_w_addr <= '0;
        end else begin
            pend <= glb_read_req;
            done <= 1'b0;
            if (pop) spad_w_addr <= spad_w_addr + ADDR_BITWIDTH'(1);
            case (state)
                IDLE: if (start) begin
                    num <= num_words;
                    spad_w_addr <= '0;
                    if (num_words == '0) done <= 1'b1;
                    else begin
                        state <= FETCH;
                        busy <= 1'b1;
                        glb_read_req <= 1'b1;
                        glb_r_addr <= base_addr;
                        issued <= NW'(1);
                    end
                end
                FETCH: if (issued == num) begin
                    state <= DRAIN;
                    glb_read_req <= 1'b0;
                end else if (can_issue) begin
                    glb_read_req <= 1'b1;
                    glb_r_addr <= glb_r_addr + ADDR_BITWIDTH'(1);
                    issued <= issued + NW'(1);
                end else glb_read_req <= 1'b0;
                DRAIN: if (empty && !pend) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef GLB_WEIGHT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start)) checksum <= '0;
        else if (pop) checksum <= checksum + spad_w_data;
    end
`endif
endmodule

// File: tb/tb_glb_weight_loader.sv
// tb_glb_weight_loader: directed bursts against a transaction-level model of the weight loader.
module tb_glb_weight_loader;
    localparam int DW = 16, AW = 10, DEPTH = 4, AMAX = 1 << AW;
    logic clk = 0, reset = 1, start = 0, spad_w_ready = 1;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0] num_words = '0;
    logic busy, done, glb_read_req, spad_w_valid;
    logic [AW-1:0] glb_r_addr, spad_w_addr;
    logic [DW-1:0] glb_r_data = 16'hDEAD, spad_w_data;
`ifdef GLB_WEIGHT_LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif
    glb_weight_loader #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .glb_read_req(glb_read_req), .glb_r_addr(glb_r_addr),
        .glb_r_data(glb_r_data), .spad_w_valid(spad_w_valid), .spad_w_ready(spad_w_ready),
        .spad_w_data(spad_w_data), .spad_w_addr(spad_w_addr)
`ifdef GLB_WEIGHT_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );
    always #5 clk = ~clk;

    logic [DW-1:0] mem_buf [AMAX];
    int n_chk = 0, n_pass = 0;
    int m_base, m_num, m_issued, m_xfer, m_wait, n_done, cyc;
    int start_cyc, first_valid_cyc, last_xfer_cyc;
    bit m_busy = 0, m_due = 0, done_seen = 0, prev_rst = 0;
    int rd_log[$];
    logic [DW-1:0] csum;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Global buffer: answers each request with its contents one cycle later, filler otherwise
    initial begin
        bit rq;
        logic [AW-1:0] ra;
        forever begin
            @(negedge clk);
            rq = glb_read_req;
            ra = glb_r_addr;
            @(posedge clk);
            #1 glb_r_data = rq ? mem_buf[ra] : 16'hDEAD;
        end
    end

    // Model and compare, once per cycle at the falling edge
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_busy = 0;
            m_due = 0;
        end else begin
            if (prev_rst) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_req", glb_read_req, 0);
                chk("rst_raddr", glb_r_addr, 0);
                chk("rst_valid", spad_w_valid, 0);
                chk("rst_wdata", spad_w_data, 0);
                chk("rst_waddr", spad_w_addr, 0);
            end
            if (glb_read_req) begin
                chk("rd_in_burst", int'(m_busy && m_issued < m_num), 1);
                chk("rd_addr", glb_r_addr, (m_base + m_issued) % AMAX);
                rd_log.push_back(glb_r_addr);
                m_issued++;
                chk("rd_room", int'(m_issued - m_xfer <= DEPTH), 1);
            end
            if (spad_w_valid) begin
                chk("wr_in_burst", int'(m_busy && m_xfer < m_issued), 1);
                chk("wr_data", spad_w_data, mem_buf[(m_base + m_xfer) % AMAX]);
                chk("wr_addr", spad_w_addr, m_xfer % AMAX);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (spad_w_ready) begin
                    csum = csum + spad_w_data;
                    m_xfer++;
                    last_xfer_cyc = cyc;
                end
            end
            if (m_due) chk("zero_done", done, 1);
            if (done) begin
                n_done++;
                done_seen = 1;
                chk("done_legal", int'(m_due || (m_busy && m_xfer == m_num && m_issued == m_num)), 1);
            end
            chk("busy", busy, int'(m_busy && !done));
            if (m_busy && m_xfer == m_num && !done) begin
                m_wait++;
                chk("drain_time", int'(m_wait < 8), 1);
            end
            m_due = 0;
            if (done) m_busy = 0;
            if (start && !m_busy) begin
                m_base = base_addr;
                m_num = num_words;
                m_issued = 0;
                m_xfer = 0;
                m_wait = 0;
                csum = 0;
                start_cyc = cyc;
                first_valid_cyc = -1;
                rd_log.delete();
                if (num_words == 0) m_due = 1;
                else m_busy = 1;
            end
        end
        prev_rst = reset;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic go(input int b, input int n);
        done_seen = 0;
        n_done = 0;
        base_addr = AW'(b);
        num_words = (AW+1)'(n);
        start = 1;
        tick;
        start = 0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done_seen && k < 300) begin
            tick;
            k++;
        end
        chk(name, done_seen, 1);
        tick;
    endtask

    task automatic wait_xfer(input int n);
        int k = 0;
        while (m_xfer < n && k < 100) begin
            tick;
            k++;
        end
        chk("xfer_reached", m_xfer, n);
    endtask

    initial begin
        for (int i = 0; i < AMAX; i++) mem_buf[i] = DW'((i * 16'h0123) ^ 16'h5A5A);
        mem_buf[16'h100] = 16'h0001;
        mem_buf[16'h101] = 16'h0002;
        mem_buf[16'h102] = 16'h0003;
        mem_buf[16'h103] = 16'hFFFF;
        repeat (3) tick;
        reset = 0;
        tick;

        // Plain burst with the scratchpad always ready
        go('h010, 8);
        wait_done("burst_done_timeout");
        chk("burst_first_rd", rd_log[0], 'h010);
        chk("burst_last_rd", rd_log[7], 'h017);
        chk("burst_reads", m_issued, 8);
        chk("burst_words", m_xfer, 8);
        chk("burst_latency", first_valid_cyc - start_cyc, 3);
        chk("burst_stream", last_xfer_cyc - first_valid_cyc, 7);
        chk("burst_done_cnt", n_done, 1);

        // Backpressure mid-burst, with a start that must be ignored while busy
        go('h040, 12);
        wait_xfer(3);
        spad_w_ready = 0;
        base_addr = 'h2A0;
        num_words = 2;
        start = 1;
        tick;
        start = 0;
        repeat (9) tick;
        chk("stall_outstanding", m_issued - m_xfer, 4);
        chk("stall_reads", m_issued, 7);
        spad_w_ready = 1;
        wait_done("bp_done_timeout");
        chk("bp_words", m_xfer, 12);
        chk("bp_base_kept", m_base, 'h040);
        chk("bp_done_cnt", n_done, 1);

        // Address wrap past the top of the buffer
        go('h3FE, 4);
        wait_done("wrap_done_timeout");
        chk("wrap_a0", rd_log[0], 'h3FE);
        chk("wrap_a1", rd_log[1], 'h3FF);
        chk("wrap_a2", rd_log[2], 'h000);
        chk("wrap_a3", rd_log[3], 'h001);

        // Zero-length burst
        go('h123, 0);
        chk("zero_reads", m_issued, 0);
        tick;
        chk("zero_done_cnt", n_done, 1);
        chk("zero_busy", busy, 0);

        // Reset in the middle of a burst, then a clean restart
        go('h080, 8);
        wait_xfer(3);
        reset = 1;
        tick;
        reset = 0;
        n_done = 0;
        repeat (6) tick;
        chk("rst_no_done", n_done, 0);
        go('h000, 5);
        wait_done("restart_done_timeout");
        chk("restart_first_rd", rd_log[0], 'h000);
        chk("restart_words", m_xfer, 5);

`ifdef GLB_WEIGHT_LOADER_CHECKSUM_EN
        go('h100, 4);
        base_addr = 'h200;
        num_words = 2;
        start = 1;
        tick;
        start = 0;
        wait_done("csum_done_timeout");
        chk("checksum", checksum, 'h0005);
        chk("checksum_model", checksum, csum);
        chk("csum_base_kept", m_base, 'h100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/glb_weight_loader.md
GLB_WEIGHT_LOADER -- requirements
Module: glb_weight_loader

Interface
REQ-001 SHALL have parameter DATA_BITWIDTH, default 16, word width of weight buffer and scratchpad.
REQ-002 SHALL have parameter ADDR_BITWIDTH, default 10, weight buffer address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, staging FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-007 SHALL have port base_addr  input  ADDR_BITWIDTH  first buffer address, sampled on accepted start.
REQ-008 SHALL have port num_words  input  ADDR_BITWIDTH+1  burst length (0..2^ADDR_BITWIDTH), sampled on accepted start.
REQ-009 SHALL have port busy  output  1  high from accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-011 SHALL have port glb_read_req  output  1  read request to weight buffer.
REQ-012 SHALL have port glb_r_addr  output  ADDR_BITWIDTH  read address.
REQ-013 SHALL have port glb_r_data  input  DATA_BITWIDTH  buffer read data, valid the cycle after glb_read_req.
REQ-014 SHALL have port spad_w_valid  output  1  word available to scratchpad.
REQ-015 SHALL have port spad_w_ready  input  1  scratchpad accepts word.
REQ-016 SHALL have port spad_w_data  output  DATA_BITWIDTH  weight word.
REQ-017 SHALL have port spad_w_addr  output  ADDR_BITWIDTH  word index within burst, 0-based.

Function
REQ-018 SHALL implement FSM IDLE -> FETCH -> DRAIN -> IDLE; start accepted only in IDLE, ignored otherwise.
REQ-019 SHALL in FETCH assert glb_read_req with glb_r_addr = (base_addr + issued) mod 2^ADDR_BITWIDTH, one address per cycle, wrapping past max address.
REQ-020 SHALL issue a read only when FIFO occupancy + in-flight reads < FIFO_DEPTH; otherwise glb_read_req=0.
REQ-021 SHALL capture glb_r_data into FIFO exactly the cycle after each issued request; glb_r_data in any other cycle is ignored (buffer drives a filler value when idle).
REQ-022 SHALL transition FETCH -> DRAIN the cycle after the last read is issued; DRAIN -> IDLE when FIFO empty and no read in flight, pulsing done for one cycle and dropping busy in the same cycle.
REQ-023 SHALL transfer a word when spad_w_valid && spad_w_ready; spad_w_valid SHALL stay high and spad_w_data/spad_w_addr stable until transfer.
REQ-024 SHALL present FIFO head directly (first-word fall-through); minimum latency start -> first spad_w_valid = 3 cycles.
REQ-025 SHALL increment spad_w_addr per transfer, reset to 0 on each accepted start.
REQ-026 SHALL sustain one word per cycle when spad_w_ready held high.
REQ-027 SHALL on num_words = 0 skip FETCH/DRAIN: no reads, done pulses the cycle after start.
REQ-028 SHALL support simultaneous FIFO push and pop without loss or occupancy change.

Reset
REQ-029 SHALL on reset force IDLE, clear FIFO, in-flight and counters; busy, done, glb_read_req, spad_w_valid = 0; glb_r_addr, spad_w_data, spad_w_addr = 0.
REQ-030 SHALL on reset mid-burst abort with no done pulse; a read in flight is discarded.

Configuration
REQ-031 SHALL with GLB_WEIGHT_LOADER_CHECKSUM_EN defined add output checksum (DATA_BITWIDTH): sum mod 2^DATA_BITWIDTH of all transferred words, cleared on reset and accepted start, final at done.
REQ-032 SHALL without GLB_WEIGHT_LOADER_CHECKSUM_EN omit the checksum port and logic; other behaviour identical.

Structure
REQ-033 SHALL place FSM state encoding and default width constants in shared package glb_pkg.
REQ-034 SHALL implement staging storage as sub-module weight_loader_fifo (sync FIFO, FWFT, full/empty/count).

Verification
REQ-035 Burst: base 0x010, num 8, ready=1 -> reads 0x010..0x017 consecutive, words out in order, spad_w_addr 0..7, done once.
REQ-036 Backpressure: ready=0 for 10 cycles mid-burst -> reads stall at FIFO_DEPTH outstanding, no loss/dup, data stable while stalled.
REQ-037 Wrap: base 0x3FE, num 4 -> addresses 0x3FE,0x3FF,0x000,0x001.
REQ-038 Zero length: num 0 -> no glb_read_req, done pulse 1 cycle after start, busy never set.
REQ-039 Reset at word 3 of 8 -> all outputs zero next cycle, no done; new start from 0x000 runs cleanly.
REQ-040 Checksum (macro on): words 1,2,3,0xFFFF -> checksum 0x0005 at done; start during busy ignored.
